// File: rtl/fifo_rd_pkg.sv
// Shared constants and occupancy encoding for the FIFO read-side stream adapter.
package fifo_rd_pkg;

    localparam int unsigned BUF_DEPTH   = 2;
    localparam int unsigned STATS_CNT_W = 32;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry register buffer: head entry drives the stream, tail absorbs one extra word.
module stream_skid_buf2 #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [1:0]       o_occ,
    output logic [WIDTH-1:0] o_head_data,
    output logic             o_valid
);
    import fifo_rd_pkg::*;

    occ_e             r_occ;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_occ  <= OCC_EMPTY;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_occ)
                OCC_EMPTY: begin
                    if (i_push) begin
                        r_head <= i_push_data;
                        r_occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({i_push, i_pop})
                        2'b10: begin
                            r_tail <= i_push_data;
                            r_occ  <= OCC_TWO;
                        end
                        2'b01: r_occ <= OCC_EMPTY;
                        2'b11: r_head <= i_push_data;
                        default: ;
                    endcase
                end
                OCC_TWO: begin
                    // Push here only happens alongside a pop; the credit rule upstream forbids otherwise.
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_push) r_tail <= i_push_data;
                        else        r_occ  <= OCC_ONE;
                    end
                end
                default: r_occ <= OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(i_push && !i_pop && r_occ == OCC_TWO))
                else $error("stream_skid_buf2 overflow: push into full buffer");
        end
    end

    assign o_occ       = r_occ;
    assign o_head_data = r_head;
    assign o_valid     = (r_occ != OCC_EMPTY);

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Turns a standard-mode sync_fifo read port into a valid/ready stream with tlast.
// Optional word/frame counters are enabled by defining FIFO_RD_STATS_EN.
module fifo_rd_stream_adapter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH:0]   i_fifo_dout,
    input  logic                  i_fifo_empty,
    output logic                  o_tvalid,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tlast,
    input  logic                  i_tready,
    output logic                  o_in_frame,
`ifdef FIFO_RD_STATS_EN
    output logic [fifo_rd_pkg::STATS_CNT_W-1:0] o_word_cnt,
    output logic [fifo_rd_pkg::STATS_CNT_W-1:0] o_frame_cnt,
`endif
    output logic                  o_busy
);
    import fifo_rd_pkg::*;

    logic                r_inflight;
    logic                r_in_frame;
    logic [1:0]          w_occ;
    logic [DATA_WIDTH:0] w_head;
    logic                w_valid;
    logic                w_pop;
    logic [2:0]          w_pending;

    assign w_pop = w_valid & i_tready;

    // Words owed to the buffer after this edge: stored + in flight - leaving now.
    assign w_pending    = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign o_fifo_rd_en = ~i_rst & ~i_fifo_empty & (w_pending < 3'(BUF_DEPTH));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inflight <= 1'b0;
            r_in_frame <= 1'b0;
        end else begin
            r_inflight <= o_fifo_rd_en;
            if (w_pop) r_in_frame <= ~o_tlast;
        end
    end

    stream_skid_buf2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (r_inflight),
        .i_push_data (i_fifo_dout),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head_data (w_head),
        .o_valid     (w_valid)
    );

    assign o_tvalid   = w_valid;
    assign o_tdata    = w_head[DATA_WIDTH-1:0];
    assign o_tlast    = w_head[DATA_WIDTH];
    assign o_in_frame = r_in_frame;
    assign o_busy     = (w_occ != OCC_EMPTY) | r_inflight;

`ifdef FIFO_RD_STATS_EN
    logic [STATS_CNT_W-1:0] r_word_cnt;
    logic [STATS_CNT_W-1:0] r_frame_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word_cnt  <= '0;
            r_frame_cnt <= '0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + 1'b1;
            if (o_tlast) r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign o_word_cnt  = r_word_cnt;
    assign o_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter with a behavioural standard-mode FIFO model.
module tb_fifo_rd_stream_adapter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_en;
    logic [DW:0]   fifo_dout = '0;
    logic          fifo_empty;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tready = 1'b0;
    logic          in_frame;
    logic          busy;
`ifdef FIFO_RD_STATS_EN
    logic [31:0]   word_cnt;
    logic [31:0]   frame_cnt;
`endif

    logic [DW:0] mem [0:4095];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    logic fifo_clr = 1'b0;
    int  n_rd = 0;
    int  n_pop = 0;
    int  tot_words = 0;
    int  tot_frames = 0;
    logic exp_frame = 1'b0;
    int  n_vec = 0;
    int  n_err = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_clr) rd_ptr <= wr_ptr;
        else if (rd_en) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
        if (rst) begin
            n_rd <= 0; n_pop <= 0; tot_words <= 0; tot_frames <= 0;
        end else begin
            if (rd_en) n_rd <= n_rd + 1;
            if (tvalid && tready) begin
                n_pop     <= n_pop + 1;
                tot_words <= tot_words + 1;
                if (tlast) tot_frames <= tot_frames + 1;
            end
        end
    end

    fifo_rd_stream_adapter #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_fifo_rd_en (rd_en),
        .i_fifo_dout  (fifo_dout),
        .i_fifo_empty (fifo_empty),
        .o_tvalid     (tvalid),
        .o_tdata      (tdata),
        .o_tlast      (tlast),
        .i_tready     (tready),
        .o_in_frame   (in_frame),
`ifdef FIFO_RD_STATS_EN
        .o_word_cnt   (word_cnt),
        .o_frame_cnt  (frame_cnt),
`endif
        .o_busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic last, input logic [DW-1:0] data);
        mem[wr_ptr] = {last, data};
        wr_ptr++;
    endtask

    // Consumes n words starting at the current FIFO read pointer, checking order,
    // frame tracking and the read credit rule every cycle.
    task automatic run_stream(input int n, input bit rnd, input bit no_bubble, input int budget);
        int idx = 0;
        int cyc = 0;
        int base = rd_ptr;
        bit started = 0;
        logic [DW:0] w;
        int owed;
        while (idx < n && cyc < budget) begin
            @(negedge clk);
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            owed = n_rd - n_pop - int'(tvalid && tready);
            check("credit", 64'(rd_en && owed >= 2), 64'd0);
            check("rd_on_empty", 64'(rd_en && fifo_empty), 64'd0);
            check("in_frame", 64'(in_frame), 64'(exp_frame));
            if (no_bubble && started) check("bubble", 64'(tvalid), 64'd1);
            if (tvalid && tready) begin
                started = 1;
                w = mem[base + idx];
                check("tdata", 64'(tdata), 64'(w[DW-1:0]));
                check("tlast", 64'(tlast), 64'(w[DW]));
                exp_frame = ~w[DW];
                idx++;
            end
            cyc++;
        end
        check("stream_done", 64'(idx), 64'(n));
    endtask

    logic [5:0] t1_rd    = 6'b000111;
    logic [5:0] t1_valid = 6'b011100;
    logic [5:0] t1_frame = 6'b011000;
    logic [5:0] t1_busy  = 6'b011110;
    logic [DW-1:0] t1_data [0:5] = '{0, 0, 32'hA, 32'hB, 32'hC, 0};

    initial begin
        // Reset with three words queued: no read may issue while in reset.
        rst = 1'b1; tready = 1'b1;
        push_word(1'b0, 32'hA); push_word(1'b0, 32'hB); push_word(1'b1, 32'hC);
        @(negedge clk); @(negedge clk); #1;
        check("rst_tvalid", 64'(tvalid), 0);
        check("rst_tdata", 64'(tdata), 0);
        check("rst_tlast", 64'(tlast), 0);
        check("rst_in_frame", 64'(in_frame), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_rd_en", 64'(rd_en), 0);

        // Free-running consumer: rd_en at 0..2, tvalid at 2..4.
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("t1_rd_en", 64'(rd_en), 64'(t1_rd[c]));
            check("t1_tvalid", 64'(tvalid), 64'(t1_valid[c]));
            check("t1_in_frame", 64'(in_frame), 64'(t1_frame[c]));
            check("t1_busy", 64'(busy), 64'(t1_busy[c]));
            if (t1_valid[c]) begin
                check("t1_tdata", 64'(tdata), 64'(t1_data[c]));
                check("t1_tlast", 64'(tlast), 64'(c == 4));
            end
            @(negedge clk);
        end

        // Backpressure: exactly two reads, head held at A.
        rst = 1'b1; exp_frame = 1'b0; tready = 1'b0;
        push_word(1'b0, 32'hA); push_word(1'b0, 32'hB); push_word(1'b1, 32'hC);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            #1;
            check("t2_rd_en", 64'(rd_en), 64'(c < 2));
            check("t2_tvalid", 64'(tvalid), 64'(c >= 2));
            check("t2_busy", 64'(busy), 64'(c >= 1));
            if (c >= 2) check("t2_hold_A", 64'(tdata), 64'hA);
            @(negedge clk);
        end
        check("t2_reads", 64'(n_rd), 64'd2);
        tready = 1'b1; #1;
        check("t2_refill_rd", 64'(rd_en), 1);
        check("t2_A", 64'(tdata), 64'hA);
        @(negedge clk); #1;
        check("t2_B_valid", 64'(tvalid), 1);
        check("t2_B", 64'(tdata), 64'hB);
        check("t2_B_frame", 64'(in_frame), 1);
        @(negedge clk); #1;
        check("t2_C_valid", 64'(tvalid), 1);
        check("t2_C", 64'(tdata), 64'hC);
        check("t2_C_last", 64'(tlast), 1);
        @(negedge clk); #1;
        check("t2_end_valid", 64'(tvalid), 0);
        check("t2_end_frame", 64'(in_frame), 0);
        check("t2_end_busy", 64'(busy), 0);

        // 100 words back to back with no bubbles.
        for (int i = 0; i < 100; i++) push_word(1'(i == 99), 32'h1000 + 32'(i));
        run_stream(100, 0, 1, 400);

        // 1000 random words under 50% ready.
        for (int i = 0; i < 1000; i++)
            push_word((i == 999) ? 1'b1 : ($urandom_range(0, 3) == 0), $urandom);
        run_stream(1000, 1, 0, 10000);

        // Frame stalls mid-way when the FIFO runs dry, then resumes.
        tready = 1'b1;
        push_word(1'b0, 32'h51); push_word(1'b0, 32'h52);
        run_stream(2, 0, 0, 50);
        repeat (4) @(negedge clk);
        #1;
        check("t5_stall_valid", 64'(tvalid), 0);
        check("t5_stall_frame", 64'(in_frame), 1);
        check("t5_stall_busy", 64'(busy), 0);
        push_word(1'b0, 32'h53); push_word(1'b1, 32'h54);
        run_stream(2, 0, 0, 50);
        @(negedge clk); #1;
        check("t5_end_frame", 64'(in_frame), 0);
        check("t5_end_valid", 64'(tvalid), 0);
`ifdef FIFO_RD_STATS_EN
        check("stats_words", 64'(word_cnt), 64'(tot_words));
        check("stats_frames", 64'(frame_cnt), 64'(tot_frames));
`endif

        // Reset mid-frame with the buffer full and a partial frame open.
        for (int i = 0; i < 5; i++) push_word(1'b0, 32'h600 + 32'(i));
        run_stream(1, 0, 0, 50);
        @(negedge clk);
        tready = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("t6_pre_valid", 64'(tvalid), 1);
        check("t6_pre_busy", 64'(busy), 1);
        check("t6_pre_frame", 64'(in_frame), 1);
        rst = 1'b1; exp_frame = 1'b0; #1;
        check("t6_rd_forced", 64'(rd_en), 0);
        @(negedge clk); #1;
        check("t6_tvalid", 64'(tvalid), 0);
        check("t6_tdata", 64'(tdata), 0);
        check("t6_tlast", 64'(tlast), 0);
        check("t6_in_frame", 64'(in_frame), 0);
        check("t6_busy", 64'(busy), 0);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0; rst = 1'b0;
        @(negedge clk); #1;
        check("t6_idle_valid", 64'(tvalid), 0);
        check("t6_idle_rd", 64'(rd_en), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
